fetch_seq: RTL and testbench

Instruction-fetch sequencer for the single-bus CPU datapath. It drives the enable and select strobes of the program counter, memory address register, memory data register and instruction register through the fetch cycle, then hands control to the execute stage and waits for it to finish. It is the only owner of the PC, MAR and IR enables outside the execute stage, and it sits beside the control unit in the top-level datapath.

---
 rtl/cpu_ctrl_pkg.sv | 15 +
 rtl/fetch_wait_cnt.sv | 26 ++
 rtl/fetch_seq.sv | 126 ++++++++++++
 tb/tb_fetch_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit constants: fetch sequencer state encodings and defaults.
package cpu_ctrl_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] FS_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] FS_ADDR   = 3'd1;
   localparam logic [STATE_W-1:0] FS_READ   = 3'd2;
   localparam logic [STATE_W-1:0] FS_LOADIR = 3'd3;
   localparam logic [STATE_W-1:0] FS_EXEC   = 3'd4;
   localparam logic [STATE_W-1:0] FS_HALT   = 3'd5;

   localparam int MEM_WAIT_DEF = 2;

endpackage

// File: rtl/fetch_wait_cnt.sv
// Loadable saturating up-counter; load clears it to 0, tc flags count >= TERM.
module fetch_wait_cnt #(
   parameter int W    = 4,
   parameter int TERM = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam logic [W-1:0] TERM_V = W'(TERM);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr || load)
         cnt <= '0;
      else if (en && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

   assign tc = (cnt >= TERM_V);

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: ADDR -> READ -> LOADIR -> EXEC handshake.
// Define FETCH_TIMEOUT_EN to add the READ timeout and sticky fault output.
module fetch_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT       = MEM_WAIT_DEF,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         run,
   input  logic         mem_rdy,
   input  logic         exec_done,
   input  logic         branch_taken,
   input  logic         halt_req,
   output logic         pc_bus_out,
   output logic         mar_en,
   output logic         pc_en,
   output logic         pc_inc,
   output logic         mem_rd,
   output logic         mdr_en,
   output logic         mdr_bus_out,
   output logic         ir_en,
   output logic         exec_start,
   output logic         busy,
   output logic         halted,
`ifdef FETCH_TIMEOUT_EN
   output logic         fault,
`endif
   output logic [2:0]   state
);

   if (MEM_WAIT < 1 || MEM_WAIT > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 127) begin : g_bad_param
      $error("fetch_seq: MEM_WAIT must be 1..15 and TIMEOUT_CYCLES 1..127");
   end

   logic [STATE_W-1:0] cur, nxt;
   logic exec_first;
   logic wait_tc, rd_ok, to_hit;
   logic s_addr, s_read, s_loadir, s_exec, s_halt, live;

   assign s_addr   = (cur == FS_ADDR);
   assign s_read   = (cur == FS_READ);
   assign s_loadir = (cur == FS_LOADIR);
   assign s_exec   = (cur == FS_EXEC);
   assign s_halt   = (cur == FS_HALT);

   // Minimum-wait counter: cleared in ADDR, counts READ cycles.
   fetch_wait_cnt #(.W(4), .TERM(MEM_WAIT - 1)) u_wait (
      .clk  (clk),
      .clr  (clr),
      .load (s_addr),
      .en   (s_read),
      .tc   (wait_tc)
   );

   assign rd_ok = s_read & wait_tc & mem_rdy;

`ifdef FETCH_TIMEOUT_EN
   logic to_tc;

   fetch_wait_cnt #(.W(7), .TERM(TIMEOUT_CYCLES - 1)) u_timeout (
      .clk  (clk),
      .clr  (clr),
      .load (s_addr),
      .en   (s_read),
      .tc   (to_tc)
   );

   // An accepted mem_rdy wins over a timeout landing in the same cycle.
   assign to_hit = s_read & to_tc & ~rd_ok;

   always_ff @(posedge clk) begin
      if (clr)
         fault <= 1'b0;
      else if (to_hit)
         fault <= 1'b1;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      nxt = cur;
      case (cur)
         FS_IDLE:   if (run) nxt = FS_ADDR;
         FS_ADDR:   nxt = FS_READ;
         FS_READ:   if (rd_ok) nxt = FS_LOADIR;
                    else if (to_hit) nxt = FS_HALT;
         FS_LOADIR: nxt = FS_EXEC;
         FS_EXEC:   if (exec_done) begin
                       if (halt_req)  nxt = FS_HALT;
                       else if (run)  nxt = FS_ADDR;
                       else           nxt = FS_IDLE;
                    end
         FS_HALT:   nxt = FS_HALT;
         default:   nxt = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cur        <= FS_IDLE;
         exec_first <= 1'b0;
      end else begin
         cur        <= nxt;
         exec_first <= (nxt == FS_EXEC) && !s_exec;
      end
   end

   // Every strobe is gated by clr so a mid-operation reset drives nothing.
   assign live        = ~clr;
   assign pc_bus_out  = live & s_addr;
   assign mar_en      = live & s_addr;
   assign pc_inc      = live & s_addr;
   assign pc_en       = live & (s_addr | (s_exec & exec_done & branch_taken));
   assign mem_rd      = live & s_read;
   assign mdr_en      = live & rd_ok;
   assign mdr_bus_out = live & s_loadir;
   assign ir_en       = live & s_loadir;
   assign exec_start  = live & s_exec & exec_first;
   assign busy        = live & (s_addr | s_read | s_loadir | s_exec);
   assign halted      = live & s_halt;
   assign state       = cur;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq; covers the timeout path when FETCH_TIMEOUT_EN is defined.
module tb_fetch_seq;

   logic clk = 1'b0;
   logic clr, run, mem_rdy, exec_done, branch_taken, halt_req;
   logic pc_bus_out, mar_en, pc_en, pc_inc, mem_rd, mdr_en, mdr_bus_out, ir_en;
   logic exec_start, busy, halted;
   logic [2:0] state;
`ifdef FETCH_TIMEOUT_EN
   logic fault;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_seq #(.MEM_WAIT(2), .TIMEOUT_CYCLES(64)) dut (
      .clk          (clk),
      .clr          (clr),
      .run          (run),
      .mem_rdy      (mem_rdy),
      .exec_done    (exec_done),
      .branch_taken (branch_taken),
      .halt_req     (halt_req),
      .pc_bus_out   (pc_bus_out),
      .mar_en       (mar_en),
      .pc_en        (pc_en),
      .pc_inc       (pc_inc),
      .mem_rd       (mem_rd),
      .mdr_en       (mdr_en),
      .mdr_bus_out  (mdr_bus_out),
      .ir_en        (ir_en),
      .exec_start   (exec_start),
      .busy         (busy),
      .halted       (halted),
`ifdef FETCH_TIMEOUT_EN
      .fault        (fault),
`endif
      .state        (state)
   );

   // {pc_bus_out,mar_en,pc_en,pc_inc,mem_rd,mdr_en,mdr_bus_out,ir_en,exec_start,busy,halted}
   logic [10:0] strobes;
   assign strobes = {pc_bus_out, mar_en, pc_en, pc_inc, mem_rd, mdr_en,
                     mdr_bus_out, ir_en, exec_start, busy, halted};

   // Input vector: {clr, run, mem_rdy, exec_done, branch_taken, halt_req}
   task automatic drive(input logic [5:0] v);
      {clr, run, mem_rdy, exec_done, branch_taken, halt_req} = v;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(6'b100000);
      #1;
      checks++;
      if (strobes !== 11'b0) begin
         failures++;
         $display("FAIL reset_c0 strobes got=%b want=%b", strobes, 11'b0);
      end
      next_cycle();
      drive(6'b100000);
      #1;
      checks++;
      if ({state, strobes} !== 14'b0) begin
         failures++;
         $display("FAIL reset_c1 got=%b want=%b", {state, strobes}, 14'b0);
      end
`ifdef FETCH_TIMEOUT_EN
      checks++;
      if (fault !== 1'b0) begin
         failures++;
         $display("FAIL reset_fault got=%b want=0", fault);
      end
`endif
      next_cycle();
   endtask

   task automatic test_fetch();
      logic [5:0]  in  [8];
      logic [13:0] exp [8];
      in  = '{6'b010000, 6'b011000, 6'b011000, 6'b011000, 6'b011000, 6'b011000, 6'b000100, 6'b000000};
      exp = '{14'b000_00000000000, 14'b001_11110000010, 14'b010_00001000010, 14'b010_00001100010,
              14'b011_00000011010, 14'b100_00000000110, 14'b100_00000000010, 14'b000_00000000000};
      for (int i = 0; i < 8; i++) begin
         drive(in[i]);
         #1;
         checks++;
         if ({state, strobes} !== exp[i]) begin
            failures++;
            $display("FAIL fetch_c%0d got=%b want=%b", i, {state, strobes}, exp[i]);
         end
         next_cycle();
      end
   endtask

   // Early mem_rdy ignored; accept in READ cycle 6; back-to-back ADDR after exec_done.
   task automatic test_slow_mem();
      logic [5:0]  in  [13];
      logic [13:0] exp [13];
      in  = '{6'b010000, 6'b010000, 6'b011000, 6'b010000, 6'b010000, 6'b010000, 6'b010000,
              6'b010000, 6'b011000, 6'b010000, 6'b010000, 6'b010100, 6'b010000};
      exp = '{14'b000_00000000000, 14'b001_11110000010, 14'b010_00001000010, 14'b010_00001000010,
              14'b010_00001000010, 14'b010_00001000010, 14'b010_00001000010, 14'b010_00001000010,
              14'b010_00001100010, 14'b011_00000011010, 14'b100_00000000110, 14'b100_00000000010,
              14'b001_11110000010};
      for (int i = 0; i < 13; i++) begin
         drive(in[i]);
         #1;
         checks++;
         if ({state, strobes} !== exp[i]) begin
            failures++;
            $display("FAIL slow_mem_c%0d got=%b want=%b", i, {state, strobes}, exp[i]);
         end
         next_cycle();
      end
   endtask

   // Starts in READ cycle 0 (left by test_slow_mem); single-cycle EXEC with branch.
   task automatic test_branch();
      logic [5:0]  in  [10];
      logic [13:0] exp [10];
      in  = '{6'b011000, 6'b011000, 6'b010000, 6'b010110, 6'b010000,
              6'b011000, 6'b011000, 6'b010000, 6'b000100, 6'b000000};
      exp = '{14'b010_00001000010, 14'b010_00001100010, 14'b011_00000011010, 14'b100_00100000110,
              14'b001_11110000010, 14'b010_00001000010, 14'b010_00001100010, 14'b011_00000011010,
              14'b100_00000000110, 14'b000_00000000000};
      for (int i = 0; i < 10; i++) begin
         drive(in[i]);
         #1;
         checks++;
         if ({state, strobes} !== exp[i]) begin
            failures++;
            $display("FAIL branch_c%0d got=%b want=%b", i, {state, strobes}, exp[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_halt();
      logic [5:0]  in  [6];
      logic [13:0] exp [6];
      in  = '{6'b010000, 6'b011000, 6'b011000, 6'b011000, 6'b011000, 6'b010101};
      exp = '{14'b000_00000000000, 14'b001_11110000010, 14'b010_00001000010, 14'b010_00001100010,
              14'b011_00000011010, 14'b100_00000000110};
      for (int i = 0; i < 6; i++) begin
         drive(in[i]);
         #1;
         checks++;
         if ({state, strobes} !== exp[i]) begin
            failures++;
            $display("FAIL halt_c%0d got=%b want=%b", i, {state, strobes}, exp[i]);
         end
         next_cycle();
      end
      for (int i = 0; i < 20; i++) begin
         drive(6'b011111);
         #1;
         checks++;
         if ({state, strobes} !== 14'b101_00000000001) begin
            failures++;
            $display("FAIL halt_hold_c%0d got=%b want=%b", i, {state, strobes}, 14'b101_00000000001);
         end
         next_cycle();
      end
      drive(6'b110000);
      #1;
      checks++;
      if ({state, strobes} !== 14'b101_00000000000) begin
         failures++;
         $display("FAIL halt_clr got=%b want=%b", {state, strobes}, 14'b101_00000000000);
      end
      next_cycle();
      drive(6'b000000);
      #1;
      checks++;
      if ({state, strobes} !== 14'b0) begin
         failures++;
         $display("FAIL halt_exit got=%b want=%b", {state, strobes}, 14'b0);
      end
      next_cycle();
   endtask

   task automatic test_mid_reset();
      logic [5:0]  in  [12];
      logic [13:0] exp [12];
      in  = '{6'b010000, 6'b010000, 6'b010000, 6'b111000, 6'b010000, 6'b010000,
              6'b011000, 6'b011000, 6'b010000, 6'b110000, 6'b000000, 6'b000000};
      exp = '{14'b000_00000000000, 14'b001_11110000010, 14'b010_00001000010, 14'b010_00000000000,
              14'b000_00000000000, 14'b001_11110000010, 14'b010_00001000010, 14'b010_00001100010,
              14'b011_00000011010, 14'b100_00000000000, 14'b000_00000000000, 14'b000_00000000000};
      for (int i = 0; i < 12; i++) begin
         drive(in[i]);
         #1;
         checks++;
         if ({state, strobes} !== exp[i]) begin
            failures++;
            $display("FAIL mid_reset_c%0d got=%b want=%b", i, {state, strobes}, exp[i]);
         end
         next_cycle();
      end
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      int bad_read = 0;
      drive(6'b010000);
      next_cycle();                    // IDLE -> ADDR
      next_cycle();                    // ADDR -> READ
      for (int i = 0; i < 64; i++) begin
         if (state !== 3'd2 || fault !== 1'b0) bad_read++;
         next_cycle();
      end
      checks++;
      if (bad_read != 0) begin
         failures++;
         $display("FAIL timeout_read got=%0d bad cycles want=0", bad_read);
      end
      checks++;
      if ({state, fault} !== {3'd5, 1'b1}) begin
         failures++;
         $display("FAIL timeout_halt got state=%0d fault=%b want state=5 fault=1", state, fault);
      end
      drive(6'b100000);
      next_cycle();
      drive(6'b000000);
      #1;
      checks++;
      if ({state, fault} !== 4'b0) begin
         failures++;
         $display("FAIL timeout_clr got state=%0d fault=%b want state=0 fault=0", state, fault);
      end
      next_cycle();
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_slow_mem();
      test_branch();
      test_halt();
      test_mid_reset();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
